countdown_ctrl: RTL and testbench
=================================

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 Parameter TIMER_W, default 12, width of preset and remaining-count fields in seconds.
REQ-002 clk  input  1  system clock, 100 MHz.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 clk_1hz  input  1  1 Hz square wave from the clock divider, synchronous to clk, used as data only and never as a clock.
REQ-005 load  input  1  one-cycle pulse; captures preset.
REQ-006 preset  input  TIMER_W  countdown start value in seconds.
REQ-007 start  input  1  one-cycle pulse; start, resume or restart.
REQ-008 pause  input  1  one-cycle pulse; freeze the count.
REQ-009 clear  input  1  one-cycle pulse; abort and zero.
REQ-010 remaining  output  TIMER_W  current count in seconds.
REQ-011 state  output  2  IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
REQ-012 busy  output  1  high in RUN or PAUSE.
REQ-013 done  output  1  one-cycle pulse on expiry.
REQ-014 expired  output  1  level, high in EXPIRED.

Function
REQ-015 Tick SHALL assert for exactly one clk cycle: the cycle after clk_1hz is sampled 1 while its previous sample was 0.
REQ-016 Command priority SHALL be clear > load > start > pause; a lower command arriving in the same cycle as a higher one SHALL be ignored.
REQ-017 clear, in any state: remaining=0, state IDLE, expired=0; the reload register is unchanged.
REQ-018 load, in any state: remaining=preset, reload register=preset, state IDLE, expired=0.
REQ-019 start behaviour by state:
- IDLE with remaining!=0: go to RUN.
- IDLE with remaining==0: ignored.
- PAUSE: go to RUN; remaining is unchanged.
- RUN: ignored.
- EXPIRED: remaining=reload register and go to RUN if the reload register !=0; otherwise ignored.
REQ-020 pause in RUN SHALL go to PAUSE; pause in any other state SHALL be ignored.
REQ-021 Ticks SHALL be ignored outside RUN and in any cycle carrying a command; there is no partial-second accounting, so the first second after start may be 0-1 s long.
REQ-022 In RUN on tick:
- remaining>1: decrement by 1.
- remaining==1: remaining=0, state EXPIRED, done pulses in the same cycle the register updates, expired=1.
REQ-023 remaining SHALL never wrap below 0.
REQ-024 All outputs SHALL be registered, except that busy SHALL be decoded from the state register; state and outputs SHALL take effect one clk cycle after the command or tick.

Reset
REQ-025 On rst, on a clk edge: state IDLE, remaining 0, reload register 0, done 0, expired 0, busy 0, edge-detect register 0.
REQ-026 rst SHALL override every command and tick in the same cycle, including rst asserted mid-RUN.

Configuration
REQ-027 Macro TIMER_AUTO_RELOAD_EN.
- Defined: the remaining==1 tick in RUN SHALL reload remaining from the reload register, stay in RUN and pulse done; expired SHALL stay 0 and EXPIRED SHALL be unreachable.
- Undefined: REQ-022 applies.

Structure
REQ-028 parameters.vh SHALL hold the state encodings, TIMER_W default and the tick-rate constant; no literals are to be duplicated in the module.
REQ-029 Rising-edge detection SHALL live in sub-module tick_edge_det (clk, rst, in, pulse); the FSM and counter stay in countdown_ctrl.

Verification (the bench drives clk_1hz directly with a short period)
REQ-030 preset=3, load, start, 3 ticks -> remaining 2,1,0; done pulses once on the third tick; state=3; expired=1.
REQ-031 preset=5, load, start, 1 tick, pause, 3 ticks -> remaining stays 4; start, 1 tick -> remaining 3.
REQ-032 pause and tick in the same cycle with remaining=4 -> state=2, remaining=4; start and clear in the same cycle -> state=0, remaining=0.
REQ-033 load with preset=0, then start -> stays IDLE, no done; EXPIRED after preset=2 followed by start -> remaining=2, state=1.
REQ-034 rst asserted in RUN with remaining=7 -> next cycle all outputs 0 and state=0.
REQ-035 With TIMER_AUTO_RELOAD_EN defined: preset=2, 6 ticks -> done pulses 3 times, state stays 1, expired stays 0.

Source files
------------

// File: rtl/countdown_ctrl_pkg.sv
// countdown_ctrl_pkg -- shared definitions for the countdown controller.
//   TIMER_W_DEF   : default width of the preset / remaining fields (seconds)
//   TICK_SECONDS  : seconds removed from the count on each clk_1hz tick
//   state_e       : externally visible state encoding (drives the state port)
//   cmd_t         : bundle of the one-cycle command pulses
package countdown_ctrl_pkg;

  localparam int unsigned TIMER_W_DEF  = 12;
  localparam int unsigned TICK_SECONDS = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  typedef struct packed {
    logic clear;
    logic load;
    logic start;
    logic pause;
  } cmd_t;

  // Any command present in this cycle; such cycles swallow a coincident tick.
  function automatic logic cmd_any(input cmd_t c);
    return |c;
  endfunction

endpackage

// File: rtl/countdown_ctrl_tick_edge_det.sv
// tick_edge_det -- registered rising-edge detector for the clk_1hz data input.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   in    : slow square wave, synchronous to clk (treated as data)
//   pulse : high for one clk cycle, the cycle after in is sampled 1 with a
//           previous sample of 0
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic prev_q;
  logic pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= in;
      pulse_q <= in & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl -- seconds countdown timer with load/start/pause/clear.
//   clk       : system clock (100 MHz)
//   rst       : synchronous active-high reset, overrides everything
//   clk_1hz   : 1 Hz square wave, sampled as data; its rising edge is a tick
//   load      : capture preset into remaining and the reload register
//   preset    : start value in seconds
//   start     : start / resume / restart
//   pause     : freeze the count while running
//   clear     : abort and zero the count
//   remaining : current count (registered)
//   state     : IDLE=0 RUN=1 PAUSE=2 EXPIRED=3 (registered)
//   busy      : RUN or PAUSE, decoded from the state register
//   done      : one-cycle pulse on expiry (registered)
//   expired   : level, high in EXPIRED (registered)
// Build option: TIMER_AUTO_RELOAD_EN -- on the final tick reload the count
// from the reload register and keep running instead of expiring.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int TIMER_W = TIMER_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_1hz,
  input  logic               load,
  input  logic [TIMER_W-1:0] preset,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  output logic [TIMER_W-1:0] remaining,
  output logic [1:0]         state,
  output logic               busy,
  output logic               done,
  output logic               expired
);

  localparam logic [TIMER_W-1:0] STEP = TIMER_W'(TICK_SECONDS);

  state_e             state_q;
  logic [TIMER_W-1:0] remaining_q;
  logic [TIMER_W-1:0] reload_q;
  logic               done_q;
  logic               expired_q;
  logic               tick;
  cmd_t               cmd;

  tick_edge_det u_tick (
    .clk   (clk),
    .rst   (rst),
    .in    (clk_1hz),
    .pulse (tick)
  );

  assign cmd = '{clear: clear, load: load, start: start, pause: pause};

  // Priority chain: clear > load > start > pause > tick. A tick is only
  // honoured in RUN and only when no command (even an ignored one) is present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      done_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cmd.clear) begin
        state_q     <= ST_IDLE;
        remaining_q <= '0;
        expired_q   <= 1'b0;
      end else if (cmd.load) begin
        state_q     <= ST_IDLE;
        remaining_q <= preset;
        reload_q    <= preset;
        expired_q   <= 1'b0;
      end else if (cmd.start) begin
        unique case (state_q)
          ST_IDLE:  if (remaining_q != '0) state_q <= ST_RUN;
          ST_PAUSE: state_q <= ST_RUN;
          ST_EXPIRED: begin
            if (reload_q != '0) begin
              remaining_q <= reload_q;
              state_q     <= ST_RUN;
              expired_q   <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (cmd.pause) begin
        if (state_q == ST_RUN) state_q <= ST_PAUSE;
      end else if (tick && !cmd_any(cmd) && state_q == ST_RUN) begin
        if (remaining_q > STEP) begin
          remaining_q <= remaining_q - STEP;
        end else if (remaining_q == STEP) begin
          done_q <= 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
          remaining_q <= reload_q;
`else
          remaining_q <= '0;
          state_q     <= ST_EXPIRED;
          expired_q   <= 1'b1;
`endif
        end
        // remaining_q == 0 in RUN: hold, never wrap.
      end
    end
  end

  assign remaining = remaining_q;
  assign state     = state_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done      = done_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl -- directed scenarios plus randomized commands/ticks,
// each step compared against a seconds-level reference model.
module tb_countdown_ctrl;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clk_1hz = 1'b0;
  logic         load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [W-1:0] preset = '0;
  logic [W-1:0] remaining;
  logic [1:0]   state;
  logic         busy, done, expired;

  int n_chk = 0, n_pass = 0;
  int dcnt = 0;
  // reference model: count in seconds, reload value, state number, done flag
  int m_rem = 0, m_rel = 0, m_st = 0, m_done = 0;

  always #5 clk = ~clk;

  countdown_ctrl #(.TIMER_W(W)) dut (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .load(load), .preset(preset),
    .start(start), .pause(pause), .clear(clear), .remaining(remaining),
    .state(state), .busy(busy), .done(done), .expired(expired)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".remaining"}, int'(remaining), m_rem);
    chk({tag, ".state"}, int'(state), m_st);
    chk({tag, ".busy"}, int'(busy), (m_st == 1 || m_st == 2) ? 1 : 0);
    chk({tag, ".done"}, int'(done), m_done);
    chk({tag, ".expired"}, int'(expired), (m_st == 3) ? 1 : 0);
    if (done === 1'b1) dcnt++;
  endtask

  // Reference behaviour for one decision cycle.
  task automatic model(input bit c, input bit l, input bit s, input bit p,
                       input bit tk, input int pv);
    m_done = 0;
    if (c) begin
      m_rem = 0; m_st = 0;
    end else if (l) begin
      m_rem = pv; m_rel = pv; m_st = 0;
    end else if (s) begin
      if (m_st == 0 && m_rem != 0) m_st = 1;
      else if (m_st == 2) m_st = 1;
      else if (m_st == 3 && m_rel != 0) begin m_rem = m_rel; m_st = 1; end
    end else if (p) begin
      if (m_st == 1) m_st = 2;
    end else if (tk && m_st == 1) begin
      if (m_rem > 1) m_rem = m_rem - 1;
      else if (m_rem == 1) begin
        m_done = 1;
`ifdef TIMER_AUTO_RELOAD_EN
        m_rem = m_rel;
`else
        m_rem = 0; m_st = 3;
`endif
      end
    end
  endtask

  // One step: optional tick landing in the same cycle as the commands.
  // Inputs change on negedges; outputs are checked on the negedge after.
  task automatic step(input string tag, input bit c, input bit l, input bit s,
                      input bit p, input bit tk, input int pv);
    preset = W'(pv);
    if (tk) begin
      clk_1hz = 1'b1;
      @(negedge clk);
      clk_1hz = 1'b0;
    end
    clear = c; load = l; start = s; pause = p;
    @(negedge clk);
    clear = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    model(c, l, s, p, tk, pv);
    check_all(tag);
  endtask

  task automatic do_rst(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_rem = 0; m_rel = 0; m_st = 0; m_done = 0;
    check_all(tag);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // basic countdown to expiry
    step("a.load", 0, 1, 0, 0, 0, 3);
    step("a.start", 0, 0, 1, 0, 0, 3);
    for (int i = 0; i < 3; i++) step("a.tick", 0, 0, 0, 0, 1, 3);
    chk("a.rem_after3", int'(remaining), `ifdef TIMER_AUTO_RELOAD_EN 3 `else 0 `endif);

    // pause freezes, start resumes
    step("b.load", 0, 1, 0, 0, 0, 5);
    step("b.start", 0, 0, 1, 0, 0, 5);
    step("b.tick", 0, 0, 0, 0, 1, 5);
    step("b.pause", 0, 0, 0, 1, 0, 5);
    for (int i = 0; i < 3; i++) step("b.ptick", 0, 0, 0, 0, 1, 5);
    chk("b.frozen", int'(remaining), 4);
    step("b.resume", 0, 0, 1, 0, 0, 5);
    step("b.tick2", 0, 0, 0, 0, 1, 5);
    chk("b.rem3", int'(remaining), 3);

    // same-cycle collisions
    step("c.load", 0, 1, 0, 0, 0, 5);
    step("c.start", 0, 0, 1, 0, 0, 5);
    step("c.tick", 0, 0, 0, 0, 1, 5);
    step("c.pause_tick", 0, 0, 0, 1, 1, 5);
    chk("c.pt_state", int'(state), 2);
    step("c.start_clear", 1, 0, 1, 0, 0, 5);
    chk("c.sc_state", int'(state), 0);

    // zero preset, restart from EXPIRED
    step("d.load0", 0, 1, 0, 0, 0, 0);
    step("d.start0", 0, 0, 1, 0, 0, 0);
    step("d.load2", 0, 1, 0, 0, 0, 2);
    step("d.start", 0, 0, 1, 0, 0, 2);
    step("d.tick", 0, 0, 0, 0, 1, 2);
    step("d.tick", 0, 0, 0, 0, 1, 2);
    step("d.restart", 0, 0, 1, 0, 0, 9);

    // reset while running
    step("e.load", 0, 1, 0, 0, 0, 7);
    step("e.start", 0, 0, 1, 0, 0, 7);
    do_rst("e.rst");

    // expiry / auto-reload count over six ticks
    step("f.load", 0, 1, 0, 0, 0, 2);
    step("f.start", 0, 0, 1, 0, 0, 2);
    dcnt = 0;
    for (int i = 0; i < 6; i++) step("f.tick", 0, 0, 0, 0, 1, 2);
    chk("f.done_count", dcnt, `ifdef TIMER_AUTO_RELOAD_EN 3 `else 1 `endif);

    // randomized mix of commands and ticks
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_rst("r.rst");
      else step("r.step",
                $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 6)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
